// File: rtl/spectral_band_energy_pkg.sv
// spectral_band_energy_pkg: shared FSM encoding and envelope/threshold defaults
//   state_t       - band engine FSM states
//   ENV_FRAC      - fraction bits of the log2 envelope (Q.4)
//   MASK_OFS_DEF  - default envelope-to-threshold offset (6.0 log2 units)
//   SPREAD_DEF    - default per-band forward spreading decay (2.0 log2 units)
package spectral_band_energy_pkg;
    typedef enum logic [2:0] {S_IDLE, S_EDGE, S_EWAIT, S_ACCUM, S_EMIT, S_ERR} state_t;
    localparam int ENV_FRAC = 4;
    localparam int MASK_OFS_DEF = 96;
    localparam int SPREAD_DEF = 32;
endpackage

// File: rtl/spectral_band_energy_log2_env.sv
// spectral_band_energy_log2_env: combinational log2 envelope (leading-one + 4-bit fraction)
//   energy  in  ACC_W  unsigned band energy
//   env     out ENV_W  0 for zero energy, else msb_pos*16 + next 4 bits, saturated
module spectral_band_energy_log2_env
    import spectral_band_energy_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int ENV_W = 16
) (
    input  logic [ACC_W-1:0] energy,
    output logic [ENV_W-1:0] env
);
    logic [31:0] pos, v;
    logic [ACC_W-1:0] norm;
    logic [ENV_FRAC-1:0] frac;
    always_comb begin
        pos = '0;
        for (int i = 0; i < ACC_W; i++) if (energy[i]) pos = 32'(i);
    end
    // Shift the leading one to the top so the fraction bits are always at a fixed
    // position; small energies get zero-filled fraction bits for free.
    assign norm = energy << (32'(ACC_W - 1) - pos);
    assign frac = ENV_FRAC'(norm >> (ACC_W - 1 - ENV_FRAC));
    assign v = (pos << ENV_FRAC) | 32'(frac);
    assign env = (energy == '0) ? '0 : (v > 32'((1 << ENV_W) - 1)) ? '1 : v[ENV_W-1:0];
endmodule

// File: rtl/spectral_band_energy.sv
// spectral_band_energy: streaming per-band energy, log2 envelope and masking threshold
//   cfg_n_coefs/cfg_n_bands  frame config, sampled when a frame starts
//   coef_*                   MDCT coefficient stream (valid/ready), channel tag, last flag
//   edge_addr/edge_data      synchronous band-edge ROM (exclusive end index, 1-cycle latency)
//   band_*                   per-band result (valid/ready), held stable until accepted
//   busy, frame_err, frame_cnt  status: not idle, framing-error pulse, completed frames
module spectral_band_energy
    import spectral_band_energy_pkg::*;
#(
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 40,
    parameter int IDX_W    = 10,
    parameter int BAND_W   = 6,
    parameter int CH_W     = 1,
    parameter int ENV_W    = 16,
    parameter int MASK_OFS = MASK_OFS_DEF,
    parameter int SPREAD   = SPREAD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  cfg_n_coefs,
    input  logic [BAND_W-1:0] cfg_n_bands,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_re,
    input  logic [COEF_W-1:0] coef_im,
    input  logic [CH_W-1:0]   coef_ch,
    input  logic              coef_last,
    output logic [BAND_W-1:0] edge_addr,
    input  logic [IDX_W-1:0]  edge_data,
    output logic              band_valid,
    input  logic              band_ready,
    output logic [BAND_W-1:0] band_idx,
    output logic [CH_W-1:0]   band_ch,
    output logic [ACC_W-1:0]  band_energy,
    output logic [ENV_W-1:0]  band_env,
    output logic [ENV_W-1:0]  band_thr,
    output logic              band_last,
    output logic              busy,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);
    state_t state;
    logic [IDX_W-1:0] n_coefs, idx, edge_q, prev_edge;
    logic [BAND_W-1:0] n_bands, band_cnt;
    logic [CH_W-1:0] ch;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ENV_W-1:0] env_nxt, thr_nxt, prev_thr, t_lvl, d_lvl;
    logic signed [2*COEF_W-1:0] re_s, im_s;
    logic [2*COEF_W:0] pwr;
    logic [ACC_W:0] sum;
    logic band_end, last_band;
    assign re_s = {{COEF_W{coef_re[COEF_W-1]}}, coef_re};
    assign im_s = {{COEF_W{coef_im[COEF_W-1]}}, coef_im};
    // Each square is non-negative and fits 2*COEF_W bits unsigned, including (-2^15)^2.
    assign pwr = {1'b0, re_s * re_s} + {1'b0, im_s * im_s};
    assign sum = {1'b0, acc} + (ACC_W+1)'(pwr);
    assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    assign band_end = idx == edge_q - 1'b1;
    assign last_band = band_cnt == n_bands;
    spectral_band_energy_log2_env #(.ACC_W(ACC_W), .ENV_W(ENV_W)) u_env (
        .energy(acc_nxt),
        .env   (env_nxt)
    );
    // prev_thr is zero at band 0, so the spreading term never wins there.
    assign t_lvl = env_nxt > ENV_W'(MASK_OFS) ? env_nxt - ENV_W'(MASK_OFS) : '0;
    assign d_lvl = prev_thr > ENV_W'(SPREAD) ? prev_thr - ENV_W'(SPREAD) : '0;
    assign thr_nxt = t_lvl > d_lvl ? t_lvl : d_lvl;
    assign coef_ready = state == S_ACCUM || state == S_ERR;
    assign busy = state != S_IDLE;
    assign edge_addr = band_cnt;
    assign band_idx = band_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            n_coefs <= '0;
            n_bands <= '0;
            ch <= '0;
            idx <= '0;
            edge_q <= '0;
            prev_edge <= '0;
            band_cnt <= '0;
            acc <= '0;
            prev_thr <= '0;
            band_valid <= 1'b0;
            band_ch <= '0;
            band_energy <= '0;
            band_env <= '0;
            band_thr <= '0;
            band_last <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: if (coef_valid) begin
                    state <= S_EDGE;
                    n_coefs <= cfg_n_coefs;
                    n_bands <= cfg_n_bands;
                    ch <= coef_ch;
                    band_cnt <= '0;
                    idx <= '0;
                    prev_edge <= '0;
                    prev_thr <= '0;
                    acc <= '0;
                end
                S_EDGE: state <= S_EWAIT;
                S_EWAIT: if (edge_data <= prev_edge || edge_data > n_coefs) begin
                    state <= S_ERR;
                    frame_err <= 1'b1;
                end else begin
                    edge_q <= edge_data;
                    state <= S_ACCUM;
                end
                S_ACCUM: if (coef_valid) begin
                    idx <= idx + 1'b1;
                    acc <= acc_nxt;
                    // coef_last must coincide exactly with the end of the last band.
                    if (coef_last != (band_end && last_band)) begin
                        state <= S_ERR;
                        frame_err <= 1'b1;
                    end else if (band_end) begin
                        state <= S_EMIT;
                        band_valid <= 1'b1;
                        band_ch <= ch;
                        band_energy <= acc_nxt;
                        band_env <= env_nxt;
                        band_thr <= thr_nxt;
                        band_last <= last_band;
                    end
                end
                S_EMIT: if (band_ready) begin
                    band_valid <= 1'b0;
                    band_last <= 1'b0;
                    acc <= '0;
                    prev_thr <= band_thr;
                    prev_edge <= edge_q;
                    if (band_last) begin
                        state <= S_IDLE;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        band_cnt <= band_cnt + 1'b1;
                        state <= S_EDGE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_spectral_band_energy.sv
// tb_spectral_band_energy: directed table-driven bench for spectral_band_energy
module tb_spectral_band_energy;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] cfg_n_coefs;
    logic [5:0] cfg_n_bands;
    logic coef_valid, coef_last, band_ready;
    logic [15:0] coef_re, coef_im;
    logic [0:0] coef_ch;
    logic [9:0] edge_data, edge_data_b;

    logic coef_ready, band_valid, band_last, busy, frame_err;
    logic [5:0] edge_addr, band_idx;
    logic [0:0] band_ch;
    logic [39:0] band_energy;
    logic [15:0] band_env, band_thr, frame_cnt;

    logic coef_ready_b, band_valid_b, band_last_b, busy_b, frame_err_b;
    logic [5:0] edge_addr_b, band_idx_b;
    logic [0:0] band_ch_b;
    logic [32:0] band_energy_b;
    logic [15:0] band_env_b, band_thr_b, frame_cnt_b;

    logic [9:0] rom [64];
    always @(posedge clk) begin
        edge_data <= rom[edge_addr];
        edge_data_b <= rom[edge_addr_b];
    end

    spectral_band_energy dut (
        .clk(clk), .rst_n(rst_n), .cfg_n_coefs(cfg_n_coefs), .cfg_n_bands(cfg_n_bands),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_re(coef_re), .coef_im(coef_im),
        .coef_ch(coef_ch), .coef_last(coef_last), .edge_addr(edge_addr), .edge_data(edge_data),
        .band_valid(band_valid), .band_ready(band_ready), .band_idx(band_idx), .band_ch(band_ch),
        .band_energy(band_energy), .band_env(band_env), .band_thr(band_thr), .band_last(band_last),
        .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    spectral_band_energy #(.ACC_W(33)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_n_coefs(cfg_n_coefs), .cfg_n_bands(cfg_n_bands),
        .coef_valid(coef_valid), .coef_ready(coef_ready_b), .coef_re(coef_re), .coef_im(coef_im),
        .coef_ch(coef_ch), .coef_last(coef_last), .edge_addr(edge_addr_b), .edge_data(edge_data_b),
        .band_valid(band_valid_b), .band_ready(band_ready), .band_idx(band_idx_b), .band_ch(band_ch_b),
        .band_energy(band_energy_b), .band_env(band_env_b), .band_thr(band_thr_b), .band_last(band_last_b),
        .busy(busy_b), .frame_err(frame_err_b), .frame_cnt(frame_cnt_b)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        int n;
        logic [39:0] energy;
        logic [15:0] env;
        logic [15:0] thr;
    } row_t;
    row_t rows [9];
    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
        bit done = 0;
        coef_valid = 1'b1;
        coef_re = re;
        coef_im = im;
        coef_last = last;
        for (int k = 0; k < 50 && !done; k++) begin
            if (coef_ready) done = 1;
            @(negedge clk);
        end
        if (!done) chk("send_timeout", 0, 1);
        coef_valid = 1'b0;
        coef_last = 1'b0;
    endtask

    task automatic handshake();
        band_ready = 1'b1;
        @(negedge clk);
        band_ready = 1'b0;
    endtask

    task automatic run_frame(input int first, input int cnt, input logic [0:0] ch, input int stall_row);
        int e = 0;
        for (int r = 0; r < cnt; r++) begin
            e += rows[first+r].n;
            rom[r] = 10'(e);
        end
        cfg_n_coefs = 10'(e);
        cfg_n_bands = 6'(cnt - 1);
        coef_ch = ch;
        for (int r = 0; r < cnt; r++) begin
            row_t w = rows[first+r];
            for (int c = 0; c < w.n; c++) send(w.re, w.im, r == cnt - 1 && c == w.n - 1);
            chk("band_valid", band_valid, 1);
            chk("band_idx", band_idx, r);
            chk("band_ch", band_ch, ch);
            chk("band_energy", band_energy, w.energy);
            chk("band_env", band_env, w.env);
            chk("band_thr", band_thr, w.thr);
            chk("band_last", band_last, r == cnt - 1);
            chk("emit_ready", coef_ready, 0);
            if (first + r == stall_row) begin
                if (r < cnt - 1) begin
                    coef_valid = 1'b1;
                    coef_re = rows[first+r+1].re;
                    coef_im = rows[first+r+1].im;
                end
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("stall_valid", band_valid, 1);
                    chk("stall_energy", band_energy, w.energy);
                    chk("stall_thr", band_thr, w.thr);
                    chk("stall_ready", coef_ready, 0);
                end
            end
            handshake();
            chk("valid_drop", band_valid, 0);
        end
        exp_frames++;
        chk("idle_busy", busy, 0);
        chk("frame_cnt", frame_cnt, exp_frames);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rows[0] = '{16'd1, 16'd0, 4, 40'd4, 16'd32, 16'd0};
        rows[1] = '{16'd1, 16'd0, 4, 40'd4, 16'd32, 16'd0};
        rows[2] = '{16'h8000, 16'h8000, 4, 40'd8589934592, 16'd528, 16'd432};
        rows[3] = '{16'd0, 16'd0, 4, 40'd0, 16'd0, 16'd400};
        rows[4] = '{16'd3, 16'd4, 2, 40'd50, 16'd89, 16'd0};
        rows[5] = '{16'd100, 16'd0, 3, 40'd30000, 16'd237, 16'd141};
        rows[6] = '{16'd0, 16'hFFFF, 1, 40'd1, 16'd0, 16'd109};
        rows[7] = '{16'd1, 16'd1, 3, 40'd6, 16'd40, 16'd77};
        rows[8] = '{16'h8000, 16'h8000, 8, 40'd17179869184, 16'd544, 16'd448};
        cfg_n_coefs = '0;
        cfg_n_bands = '0;
        coef_valid = 1'b0;
        coef_last = 1'b0;
        coef_re = '0;
        coef_im = '0;
        coef_ch = '0;
        band_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", coef_ready, 0);
        chk("rst_valid", band_valid, 0);
        chk("rst_energy", band_energy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_edge_addr", edge_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 2, 1'b0, -1);
        run_frame(2, 2, 1'b1, -1);

        // coef_last arriving early, in the middle of band 1
        cfg_n_coefs = 10'd8;
        cfg_n_bands = 6'd1;
        rom[0] = 10'd4;
        rom[1] = 10'd8;
        coef_ch = 1'b0;
        for (int c = 0; c < 4; c++) send(16'd1, 16'd0, 1'b0);
        chk("err_a_band0", band_valid, 1);
        handshake();
        send(16'd1, 16'd0, 1'b1);
        chk("err_a_pulse", frame_err, 1);
        chk("err_a_novalid", band_valid, 0);
        chk("err_a_nolast", band_last, 0);
        chk("err_a_ready", coef_ready, 1);
        @(negedge clk);
        chk("err_a_pulse_end", frame_err, 0);
        chk("err_a_idle", busy, 0);
        chk("err_a_frame_cnt", frame_cnt, exp_frames);

        run_frame(4, 4, 1'b0, 5);

        // non-increasing band edge
        rom[0] = 10'd4;
        rom[1] = 10'd4;
        cfg_n_coefs = 10'd8;
        cfg_n_bands = 6'd1;
        for (int c = 0; c < 4; c++) send(16'd2, 16'd0, 1'b0);
        chk("err_c_band0", band_energy, 16);
        handshake();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (frame_err) seen = 1;
            @(negedge clk);
        end
        chk("err_c_pulse", seen, 1);
        chk("err_c_idle", busy, 0);
        chk("err_c_frame_cnt", frame_cnt, exp_frames);

        // full-scale input: default width holds 2^34, the 33-bit instance saturates
        run_frame(8, 1, 1'b0, -1);
        chk("sat_energy", band_energy_b, 64'd8589934591);
        chk("sat_env", band_env_b, 527);
        chk("sat_thr", band_thr_b, 431);
        chk("sat_frame_cnt", frame_cnt_b, exp_frames);

        // reset in the middle of accumulation
        cfg_n_coefs = 10'd8;
        cfg_n_bands = 6'd1;
        rom[0] = 10'd4;
        rom[1] = 10'd8;
        send(16'd5, 16'd5, 1'b0);
        send(16'd5, 16'd5, 1'b0);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", coef_ready, 0);
        chk("mid_rst_valid", band_valid, 0);
        chk("mid_rst_energy", band_energy, 0);
        chk("mid_rst_env", band_env, 0);
        chk("mid_rst_thr", band_thr, 0);
        chk("mid_rst_idx", band_idx, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        exp_frames = 0;
        @(negedge clk);
        run_frame(0, 2, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
